// File: rtl/mul_seq_if.sv
// Handshake bundle for mul_seq: operand side (in_*) and result side (out_*).
interface mul_seq_if #(
  parameter int unsigned WIDTH_A = 4,
  parameter int unsigned WIDTH_B = 4
);
  localparam int unsigned WIDTH_Y = WIDTH_A + WIDTH_B;

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH_A-1:0] a;
  logic [WIDTH_B-1:0] b;
  logic               is_signed;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH_Y-1:0] y;
  logic               busy;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, y, busy
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, y, busy
  );
endinterface

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier, one multiplier bit per clock, signed/unsigned per
// transaction via sign-magnitude: magnitudes are multiplied, sign applied at the end.
module mul_seq #(
  parameter int unsigned WIDTH_A = 4,
  parameter int unsigned WIDTH_B = 4
) (
  input logic     clk,
  input logic     rst,
  mul_seq_if.slave bus
);
  localparam int unsigned WIDTH_Y = WIDTH_A + WIDTH_B;
  localparam int unsigned CW      = $clog2(WIDTH_B + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q;
  logic [WIDTH_Y-1:0] mcand_q;
  logic [WIDTH_B-1:0] mplier_q;
  logic [WIDTH_Y-1:0] acc_q;
  logic [WIDTH_Y-1:0] acc_d;
  logic [WIDTH_Y-1:0] y_q;
  logic [CW-1:0]      count_q;
  logic               neg_q;
  logic               out_valid_q;

  logic [WIDTH_A-1:0] mag_a;
  logic [WIDTH_B-1:0] mag_b;
  logic               neg_d;

  // Most-negative operands negate to themselves, which read as unsigned is 2^(W-1).
  always_comb begin
    mag_a = (bus.is_signed && bus.a[WIDTH_A-1]) ? -bus.a : bus.a;
    mag_b = (bus.is_signed && bus.b[WIDTH_B-1]) ? -bus.b : bus.b;
    neg_d = bus.is_signed && (bus.a[WIDTH_A-1] ^ bus.b[WIDTH_B-1]);
    acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      count_q     <= '0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            mcand_q  <= WIDTH_Y'(mag_a);
            mplier_q <= mag_b;
            neg_q    <= neg_d;
            acc_q    <= '0;
            count_q  <= CW'(WIDTH_B);
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q - 1'b1;
          if (count_q == CW'(1)) begin
            y_q         <= neg_q ? -acc_d : acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == BUSY);
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq at 4x4 (directed + random) and 8x6 (random).
module tb_mul_seq;
  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   got0  = 0;
  int   got1  = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  always #5 clk = ~clk;

  mul_seq_if #(.WIDTH_A(4), .WIDTH_B(4)) if0 ();
  mul_seq_if #(.WIDTH_A(8), .WIDTH_B(6)) if1 ();

  mul_seq #(.WIDTH_A(4), .WIDTH_B(4)) u0 (.clk(clk), .rst(rst0), .bus(if0));
  mul_seq #(.WIDTH_A(8), .WIDTH_B(6)) u1 (.clk(clk), .rst(rst1), .bus(if1));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input int wa, input int wb,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input bit s);
    longint av, bv, p;
    av = longint'(a);
    bv = longint'(b);
    if (s && a[wa-1]) av = av - (longint'(1) << wa);
    if (s && b[wb-1]) bv = bv - (longint'(1) << wb);
    p = av * bv;
    return 64'(p) & ((64'd1 << (wa + wb)) - 64'd1);
  endfunction

  always @(negedge clk) begin
    if (rst0) q0.delete();
    else begin
      if (if0.in_valid && if0.in_ready)
        q0.push_back(ref_mul(4, 4, 32'(if0.a), 32'(if0.b), if0.is_signed));
      if (if0.out_valid && if0.out_ready) begin
        if (q0.size() == 0) check("sb0_underflow", 64'd1, 64'd0);
        else check("sb0_y", 64'(if0.y), q0.pop_front());
        got0++;
      end
    end
    if (rst1) q1.delete();
    else begin
      if (if1.in_valid && if1.in_ready)
        q1.push_back(ref_mul(8, 6, 32'(if1.a), 32'(if1.b), if1.is_signed));
      if (if1.out_valid && if1.out_ready) begin
        if (q1.size() == 0) check("sb1_underflow", 64'd1, 64'd0);
        else check("sb1_y", 64'(if1.y), q1.pop_front());
        got1++;
      end
    end
  end

  // Entered and left at posedge+1; returns just after the accept edge.
  task automatic send0(input logic [3:0] a, input logic [3:0] b, input logic s);
    int unsigned n = 0;
    if0.a = a; if0.b = b; if0.is_signed = s; if0.in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!if0.in_ready && n < 200);
    if (n >= 200) check("send0_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
  endtask

  task automatic send1(input logic [7:0] a, input logic [5:0] b, input logic s);
    int unsigned n = 0;
    if1.a = a; if1.b = b; if1.is_signed = s; if1.in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!if1.in_ready && n < 200);
    if (n >= 200) check("send1_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
  endtask

  // Waits for out_valid, counting edges since the accept edge; ends on that negedge.
  task automatic wait_out0(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!if0.out_valid && lat < 50);
  endtask

  task automatic run0(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic s, input logic [7:0] exp_y);
    int lat;
    send0(a, b, s);
    wait_out0(lat);
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check({tag, "_y"}, 64'(if0.y), 64'(exp_y));
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int guard;
    int base;
    bit fed;
    if0.in_valid = 1'b0; if0.a = '0; if0.b = '0; if0.is_signed = 1'b0; if0.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.is_signed = 1'b0; if1.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(if0.in_ready), 64'd1);
    check("rst_out_valid", 64'(if0.out_valid), 64'd0);
    check("rst_y", 64'(if0.y), 64'd0);
    check("rst_busy", 64'(if0.busy), 64'd0);
    @(posedge clk); #1;

    run0("t1", 4'd3, 4'd5, 1'b0, 8'h0F);
    run0("t2u", 4'd15, 4'd15, 1'b0, 8'hE1);
    run0("t2s", 4'h8, 4'h8, 1'b1, 8'h40);
    run0("t3a", 4'hD, 4'd5, 1'b1, 8'hF1);
    run0("t3b", 4'h8, 4'd7, 1'b1, 8'hC8);
    run0("zero", 4'h0, 4'h9, 1'b1, 8'h00);

    // Backpressure: result held, new operands refused while DONE.
    if0.out_ready = 1'b0;
    send0(4'd5, 4'd6, 1'b0);
    wait_out0(lat);
    check("t4_lat", 64'(lat), 64'd4);
    if0.a = 4'd1; if0.b = 4'd1; if0.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t4_hold_valid", 64'(if0.out_valid), 64'd1);
      check("t4_hold_y", 64'(if0.y), 64'd30);
      check("t4_hold_in_ready", 64'(if0.in_ready), 64'd0);
    end
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
    if0.out_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_idle_in_ready", 64'(if0.in_ready), 64'd1);
    check("t4_idle_out_valid", 64'(if0.out_valid), 64'd0);
    check("t4_y_kept", 64'(if0.y), 64'd30);

    // Reset pulse while BUSY with count=2 discards the in-flight product.
    send0(4'd7, 4'd7, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    check("t6_busy", 64'(if0.busy), 64'd1);
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
    @(negedge clk);
    check("t6_in_ready", 64'(if0.in_ready), 64'd1);
    check("t6_out_valid", 64'(if0.out_valid), 64'd0);
    check("t6_y", 64'(if0.y), 64'd0);
    check("t6_busy_low", 64'(if0.busy), 64'd0);
    @(posedge clk); #1;
    run0("t6_fresh", 4'd2, 4'd3, 1'b0, 8'd6);

    // Random back-to-back, 4x4.
    base = got0; fed = 1'b0; guard = 0;
    fork
      begin
        for (int i = 0; i < 20; i++)
          send0(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
        fed = 1'b1;
      end
      begin
        while (!(fed && q0.size() == 0) && guard < 3000) begin
          @(posedge clk); #1;
          if0.out_ready = 1'($urandom_range(0, 1));
          guard++;
        end
      end
    join
    if0.out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("t5a_guard", 64'(guard < 3000), 64'd1);
    check("t5a_count", 64'(got0 - base), 64'd20);
    check("t5a_empty", 64'(q0.size()), 64'd0);

    // Random back-to-back, 8x6.
    base = got1; fed = 1'b0; guard = 0;
    fork
      begin
        for (int i = 0; i < 20; i++)
          send1(8'($urandom), 6'($urandom), 1'($urandom_range(0, 1)));
        fed = 1'b1;
      end
      begin
        while (!(fed && q1.size() == 0) && guard < 3000) begin
          @(posedge clk); #1;
          if1.out_ready = 1'($urandom_range(0, 1));
          guard++;
        end
      end
    join
    if1.out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("t5b_guard", 64'(guard < 3000), 64'd1);
    check("t5b_count", 64'(got1 - base), 64'd20);
    check("t5b_empty", 64'(q1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
